// File: rtl/pht_pkg.sv
// Shared PHT types: 2-bit counter encoding and saturating update rule.
// Also used by the PHT storage model.
package pht_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  localparam ctr_t PHT_INIT_VALUE = WNT;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  function automatic ctr_t pht_sat_next(input ctr_t cur, input logic taken);
    if (taken) return (cur == ST) ? ST : cur + 2'd1;
    else       return (cur == SNT) ? SNT : cur - 2'd1;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Pending branch-update queue holding {index,taken}.
// Cleared synchronously on reset or flush.
module pht_update_fifo
  import pht_pkg::*;
#(
  parameter int W     = 11,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [AW:0]   o_count,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push}
                     - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wp] <= i_din;
  end

endmodule

// File: rtl/pht_update_controller.sv
// Owns every PHT counter write: init sweep after reset/flush,
// then queued read-modify-write updates with same-index bypass.
module pht_update_controller
  import pht_pkg::*;
#(
  parameter int   INDEX_BITS = 10,
  parameter int   TABLE_SIZE = 1024,
  parameter int   FIFO_DEPTH = 4,
  parameter ctr_t INIT_VALUE = PHT_INIT_VALUE
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_flush_req,
  output logic                  o_busy,
  input  logic                  i_upd_valid,
  output logic                  o_upd_ready,
  input  logic [INDEX_BITS-1:0] i_upd_index,
  input  logic                  i_upd_taken,
  output logic                  o_mem_rd_en,
  output logic [INDEX_BITS-1:0] o_mem_rd_index,
  input  logic [1:0]            i_mem_rd_data,
  output logic                  o_mem_wr_en,
  output logic [INDEX_BITS-1:0] o_mem_wr_index,
  output logic [1:0]            o_mem_wr_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = INDEX_BITS + 1;
  localparam logic [INDEX_BITS-1:0] LAST = INDEX_BITS'(TABLE_SIZE - 1);

  state_t                r_state;
  state_t                w_state_nx;
  logic [INDEX_BITS-1:0] r_ptr;
  logic [INDEX_BITS-1:0] w_ptr_nx;

  logic                  r_s1_valid;
  logic [INDEX_BITS-1:0] r_s1_index;
  logic                  r_s1_taken;

  logic                  r_prev_wr_en;
  logic [INDEX_BITS-1:0] r_prev_wr_index;
  ctr_t                  r_prev_wr_data;

  logic                  w_run;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_clr;
  logic [FW-1:0]         w_head;
  logic [CW-1:0]         w_count;
  logic                  w_empty;
  logic                  w_bypass;
  ctr_t                  w_cur;

  assign w_run  = (r_state == S_RUN) & ~i_reset;
  assign w_clr  = i_reset | i_flush_req;

  assign o_upd_ready = w_run & ~i_flush_req
                     & (w_count < CW'(FIFO_DEPTH));
  assign w_push = i_upd_valid & o_upd_ready;
  assign w_pop  = w_run & ~i_flush_req & ~w_empty;

  assign o_mem_rd_en    = w_pop;
  assign o_mem_rd_index = w_head[FW-1:1];

  pht_update_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clock),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_din   ({i_upd_index, i_upd_taken}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Read-first storage misses the write issued in the same cycle as our read.
  assign w_bypass = r_prev_wr_en & (r_prev_wr_index == r_s1_index);
  assign w_cur    = w_bypass ? r_prev_wr_data : i_mem_rd_data;

  always_comb begin
    w_state_nx     = r_state;
    w_ptr_nx       = r_ptr;
    o_busy         = 1'b1;
    o_mem_wr_en    = 1'b0;
    o_mem_wr_index = r_ptr;
    o_mem_wr_data  = INIT_VALUE;
    unique case (r_state)
      S_INIT: begin
        o_mem_wr_en = 1'b1;
        w_ptr_nx    = r_ptr + 1'b1;
        if (r_ptr == LAST) w_state_nx = S_RUN;
        if (i_flush_req) begin
          w_ptr_nx   = '0;
          w_state_nx = S_INIT;
        end
      end
      S_RUN: begin
        o_busy = 1'b0;
        if (r_s1_valid) begin
          o_mem_wr_en    = 1'b1;
          o_mem_wr_index = r_s1_index;
          o_mem_wr_data  = pht_sat_next(w_cur, r_s1_taken);
        end
        if (i_flush_req) begin
          w_ptr_nx   = '0;
          w_state_nx = S_INIT;
        end
      end
      default: ;
    endcase
    if (i_reset) begin
      o_busy      = 1'b1;
      o_mem_wr_en = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_INIT;
      r_ptr        <= '0;
      r_s1_valid   <= 1'b0;
      r_prev_wr_en <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_ptr        <= w_ptr_nx;
      r_s1_valid   <= w_pop;
      r_prev_wr_en <= o_mem_wr_en;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_pop) begin
      r_s1_index <= w_head[FW-1:1];
      r_s1_taken <= w_head[0];
    end
    r_prev_wr_index <= o_mem_wr_index;
    r_prev_wr_data  <= o_mem_wr_data;
  end

endmodule

// File: tb/tb_pht_update_controller.sv
// Directed bench for pht_update_controller with a read-first
// PHT storage model and a write log sampled on the falling edge.
module tb_pht_update_controller;
  import pht_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       valid;
  logic [9:0] idx;
  logic       taken;
  logic       o_busy;
  logic       o_upd_ready;
  logic       o_mem_rd_en;
  logic [9:0] o_mem_rd_index;
  logic [1:0] rd_data = 2'b00;
  logic       o_mem_wr_en;
  logic [9:0] o_mem_wr_index;
  logic [1:0] o_mem_wr_data;

  int errors = 0;
  int checks = 0;

  logic [1:0] mem [1024];
  logic [1:0] rd_pend = 2'b00;
  int cyc = 0;
  int wl_idx[$];
  int wl_dat[$];
  int wl_cyc[$];
  int pl_cyc[$];

  always #5 clk = ~clk;

  pht_update_controller dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_flush_req    (flush),
    .o_busy         (o_busy),
    .i_upd_valid    (valid),
    .o_upd_ready    (o_upd_ready),
    .i_upd_index    (idx),
    .i_upd_taken    (taken),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_rd_index (o_mem_rd_index),
    .i_mem_rd_data  (rd_data),
    .o_mem_wr_en    (o_mem_wr_en),
    .o_mem_wr_index (o_mem_wr_index),
    .o_mem_wr_data  (o_mem_wr_data)
  );

  // storage model: read returns the pre-write value
  always @(negedge clk) begin
    if (o_mem_rd_en) rd_pend = mem[o_mem_rd_index];
    if (o_mem_wr_en) begin
      mem[o_mem_wr_index] = o_mem_wr_data;
      wl_idx.push_back(int'(o_mem_wr_index));
      wl_dat.push_back(int'(o_mem_wr_data));
      wl_cyc.push_back(cyc);
    end
    if (valid && o_upd_ready) pl_cyc.push_back(cyc);
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    rd_data = rd_pend;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wl_idx.delete();
    wl_dat.delete();
    wl_cyc.delete();
    pl_cyc.delete();
  endtask

  task automatic wait_run(output int nbusy, output bit ok);
    nbusy = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (o_upd_ready) begin
        ok = 1'b1;
        break;
      end
      if (o_busy) nbusy++;
      step();
    end
    step();
  endtask

  function automatic int bad_entries();
    int n = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== 2'b01) n++;
    return n;
  endfunction

  function automatic int non_init_writes();
    int n = 0;
    foreach (wl_dat[i])
      if (wl_dat[i] != 1) n++;
    return n;
  endfunction

  task automatic test_reset();
    int n;
    bit ok;
    rst = 1'b1;
    flush = 1'b0;
    valid = 1'b0;
    idx = '0;
    taken = 1'b0;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({o_busy, o_upd_ready, o_mem_rd_en, o_mem_wr_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 1000",
               {o_busy, o_upd_ready, o_mem_rd_en, o_mem_wr_en});
    end
    step();
    rst = 1'b0;
    clear_log();
    wait_run(n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_timeout: upd_ready never rose");
    end
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL reset_busy_cycles: got %0d want 1024", n);
    end
    checks++;
    if (bad_entries() !== 0) begin
      errors++;
      $display("FAIL reset_table: %0d entries not 01", bad_entries());
    end
    checks++;
    if (wl_idx.size() != 1024) begin
      errors++;
      $display("FAIL reset_sweep_writes: got %0d want 1024", wl_idx.size());
    end else if (wl_idx[0] != 0 || wl_idx[1023] != 1023) begin
      errors++;
      $display("FAIL reset_sweep_order: first %0d last %0d want 0 1023",
               wl_idx[0], wl_idx[1023]);
    end
  endtask

  task automatic test_updates();
    logic tk [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int   ex [4] = '{2, 3, 3, 2};
    for (int k = 0; k < 4; k++) begin
      clear_log();
      valid = 1'b1;
      idx = 10'd5;
      taken = tk[k];
      step();
      valid = 1'b0;
      repeat (3) step();
      checks++;
      if (wl_idx.size() != 1 || pl_cyc.size() != 1) begin
        errors++;
        $display("FAIL upd%0d_count: writes %0d pushes %0d want 1 1",
                 k, wl_idx.size(), pl_cyc.size());
      end else begin
        checks++;
        if (wl_idx[0] != 5 || wl_dat[0] != ex[k]) begin
          errors++;
          $display("FAIL upd%0d_data: got idx %0d val %0d want idx 5 val %0d",
                   k, wl_idx[0], wl_dat[0], ex[k]);
        end
        checks++;
        if (wl_cyc[0] - pl_cyc[0] != 2) begin
          errors++;
          $display("FAIL upd%0d_latency: got %0d want 2",
                   k, wl_cyc[0] - pl_cyc[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    valid = 1'b1;
    idx = 10'd7;
    taken = 1'b1;
    step();
    step();
    valid = 1'b0;
    repeat (4) step();
    checks++;
    if (wl_idx.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", wl_idx.size());
    end else begin
      checks++;
      if (wl_idx[0] != 7 || wl_idx[1] != 7 ||
          wl_dat[0] != 2 || wl_dat[1] != 3) begin
        errors++;
        $display("FAIL b2b_data: got %0d/%0d %0d/%0d want 7/2 7/3",
                 wl_idx[0], wl_dat[0], wl_idx[1], wl_dat[1]);
      end
      checks++;
      if (wl_cyc[1] - wl_cyc[0] != 1) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d want 1", wl_cyc[1] - wl_cyc[0]);
      end
    end
  endtask

  task automatic test_burst();
    int   bi [6] = '{10, 11, 10, 10, 12, 10};
    logic bt [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int   be [6] = '{2, 0, 3, 3, 0, 2};
    int   nrdy = 0;
    clear_log();
    for (int k = 0; k < 6; k++) begin
      valid = 1'b1;
      idx = 10'(bi[k]);
      taken = bt[k];
      @(negedge clk);
      if (!o_upd_ready) nrdy++;
      step();
    end
    valid = 1'b0;
    repeat (4) step();
    checks++;
    if (nrdy != 0) begin
      errors++;
      $display("FAIL burst_ready: low %0d cycles want 0", nrdy);
    end
    checks++;
    if (wl_idx.size() != 6) begin
      errors++;
      $display("FAIL burst_count: got %0d want 6", wl_idx.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (wl_idx[k] != bi[k] || wl_dat[k] != be[k]) begin
          errors++;
          $display("FAIL burst_w%0d: got %0d/%0d want %0d/%0d",
                   k, wl_idx[k], wl_dat[k], bi[k], be[k]);
        end
      end
      checks++;
      if (wl_cyc[5] - wl_cyc[0] != 5) begin
        errors++;
        $display("FAIL burst_rate: span %0d want 5", wl_cyc[5] - wl_cyc[0]);
      end
    end
  endtask

  task automatic test_flush();
    int n;
    bit ok;
    clear_log();
    valid = 1'b1;
    taken = 1'b1;
    idx = 10'd20;
    step();
    idx = 10'd21;
    step();
    idx = 10'd22;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (o_upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b want 0", o_upd_ready);
    end
    step();
    flush = 1'b0;
    valid = 1'b0;
    wait_run(n, ok);
    checks++;
    if (!ok || n !== 1024) begin
      errors++;
      $display("FAIL flush_busy: got %0d ok %0d want 1024 1", n, ok);
    end
    checks++;
    if (pl_cyc.size() != 2) begin
      errors++;
      $display("FAIL flush_pushes: got %0d want 2", pl_cyc.size());
    end
    checks++;
    if (wl_idx.size() != 1025) begin
      errors++;
      $display("FAIL flush_writes: got %0d want 1025", wl_idx.size());
    end else begin
      checks++;
      if (wl_idx[0] != 20 || wl_dat[0] != 2) begin
        errors++;
        $display("FAIL flush_s1_write: got %0d/%0d want 20/2",
                 wl_idx[0], wl_dat[0]);
      end
      checks++;
      if (wl_idx[1] != 0 || wl_cyc[1] - wl_cyc[0] != 1) begin
        errors++;
        $display("FAIL flush_sweep_start: idx %0d gap %0d want 0 1",
                 wl_idx[1], wl_cyc[1] - wl_cyc[0]);
      end
    end
    checks++;
    if (non_init_writes() != 1) begin
      errors++;
      $display("FAIL flush_dropped: %0d non-01 writes want 1",
               non_init_writes());
    end
    checks++;
    if (bad_entries() !== 0) begin
      errors++;
      $display("FAIL flush_table: %0d entries not 01", bad_entries());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    bit found = 1'b0;
    clear_log();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (o_mem_wr_en && o_mem_wr_index == 10'd499) found = 1'b1;
      step();
      if (found) break;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_ptr499: sweep never reached 499");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_mem_wr_en !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_sweep_suppress: wr_en %b busy %b want 0 1",
               o_mem_wr_en, o_busy);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_mem_wr_en !== 1'b1 || o_mem_wr_index !== 10'd0) begin
      errors++;
      $display("FAIL rstmid_restart: wr_en %b idx %0d want 1 0",
               o_mem_wr_en, o_mem_wr_index);
    end
    step();
    wait_run(n, ok);
    checks++;
    if (!ok || n !== 1023) begin
      errors++;
      $display("FAIL rstmid_sweep_len: got %0d ok %0d want 1023 1", n, ok);
    end
    clear_log();
    valid = 1'b1;
    idx = 10'd30;
    taken = 1'b1;
    step();
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_mem_rd_en !== 1'b1 || o_mem_rd_index !== 10'd30) begin
      errors++;
      $display("FAIL rstmid_issue: rd_en %b idx %0d want 1 30",
               o_mem_rd_en, o_mem_rd_index);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_rmw_suppress: wr_en %b want 0", o_mem_wr_en);
    end
    step();
    rst = 1'b0;
    wait_run(n, ok);
    checks++;
    if (!ok || n !== 1024) begin
      errors++;
      $display("FAIL rstmid_resweep: got %0d ok %0d want 1024 1", n, ok);
    end
    checks++;
    if (non_init_writes() != 0 || bad_entries() != 0) begin
      errors++;
      $display("FAIL rstmid_table: non-01 writes %0d bad %0d want 0 0",
               non_init_writes(), bad_entries());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'b11;
    test_reset();
    test_updates();
    test_back_to_back();
    test_burst();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
